// File: rtl/register_file_if.sv
// Writeback-to-register-file and decode read-port bundle.
// master: pipeline side driving writes/read indices; slave: the register file.
interface register_file_if #(
    parameter int unsigned XLEN = 64
);
    logic            wb_RegWrite;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_registerout;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            init_busy;

    modport master (
        output wb_RegWrite, wb_rd, wb_registerout, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, init_busy
    );

    modport slave (
        input  wb_RegWrite, wb_rd, wb_registerout, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, init_busy
    );
endinterface

// File: rtl/register_file.sv
// Integer register file: post-reset clear sweep of x1..x31, two combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to matching read ports.
module register_file #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    register_file_if.slave    bus
);
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t          r_state;
    logic [4:0]      r_clr_idx;
    logic            r_init_busy;
    logic [XLEN-1:0] r_regs [1:NREGS-1];

    logic            w_wr_en;
    logic            w_rd_en;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    assign w_wr_en = bus.wb_RegWrite && (bus.wb_rd != '0);
    // Reads are gated while reset is high so the ports show zero even before the FSM returns to CLEAR.
    assign w_rd_en = (r_state == READY) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= CLEAR;
            r_clr_idx   <= 5'd1;
            r_init_busy <= 1'b1;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_regs[r_clr_idx] <= '0;
                    r_clr_idx         <= r_clr_idx + 5'd1;
                    if (r_clr_idx == 5'(NREGS - 1)) begin
                        r_state     <= READY;
                        r_init_busy <= 1'b0;
                    end
                end
                READY: begin
                    if (w_wr_en) begin
                        r_regs[bus.wb_rd] <= bus.wb_registerout;
                    end
                end
                default: begin
                    r_state     <= CLEAR;
                    r_clr_idx   <= 5'd1;
                    r_init_busy <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_rs1_data = '0;
        w_rs2_data = '0;
        if (w_rd_en) begin
            if (bus.rs1_addr != '0) begin
                w_rs1_data = r_regs[bus.rs1_addr];
            end
            if (bus.rs2_addr != '0) begin
                w_rs2_data = r_regs[bus.rs2_addr];
            end
`ifdef REGFILE_BYPASS_EN
            if (w_wr_en && (bus.wb_rd == bus.rs1_addr)) begin
                w_rs1_data = bus.wb_registerout;
            end
            if (w_wr_en && (bus.wb_rd == bus.rs2_addr)) begin
                w_rs2_data = bus.wb_registerout;
            end
`else
`endif
        end
    end

    assign bus.rs1_data  = w_rs1_data;
    assign bus.rs2_data  = w_rs2_data;
    assign bus.init_busy = r_init_busy;
endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: sweep timing, read/write, x0, bypass, resets.
module tb_register_file;
    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    int   n_edges;

    register_file_if #(.XLEN(64)) bus ();

    register_file #(.XLEN(64), .NREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Counts edges until init_busy drops, bounded so a stuck sweep still ends the run.
    task automatic wait_ready(output int n);
        n = 0;
        while (bus.init_busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        logic [63:0] exp_pre;
        n_pass  = 0;
        n_total = 0;

        reset              = 1'b1;
        bus.wb_RegWrite    = 1'b0;
        bus.wb_rd          = 5'd0;
        bus.wb_registerout = '0;
        bus.rs1_addr       = 5'd5;
        bus.rs2_addr       = 5'd5;

        // 1. reset for 3 cycles, then sweep with a write to x5 held throughout
        repeat (3) tick();
        check("reset_busy", 64'(bus.init_busy), 64'd1);
        check("reset_rs1", bus.rs1_data, 64'd0);
        check("reset_rs2", bus.rs2_data, 64'd0);
        reset              = 1'b0;
        bus.wb_RegWrite    = 1'b1;
        bus.wb_rd          = 5'd5;
        bus.wb_registerout = 64'hAA;
        #1;
        check("sweep_rs1_zero", bus.rs1_data, 64'd0);
        tick();
        check("sweep_busy_after_1", 64'(bus.init_busy), 64'd1);
        wait_ready(n_edges);
        check("sweep_edges", 64'(n_edges + 1), 64'd31);
        bus.wb_RegWrite = 1'b0;
        #1;
        check("sweep_writes_dropped_x5", bus.rs1_data, 64'd0);

        // 2. basic write/read
        bus.wb_RegWrite    = 1'b1;
        bus.wb_rd          = 5'd7;
        bus.wb_registerout = 64'h0123_4567_89AB_CDEF;
        tick();
        bus.wb_rd          = 5'd31;
        bus.wb_registerout = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        bus.wb_RegWrite = 1'b0;
        bus.rs1_addr    = 5'd7;
        bus.rs2_addr    = 5'd31;
        #1;
        check("read_x7", bus.rs1_data, 64'h0123_4567_89AB_CDEF);
        check("read_x31", bus.rs2_data, 64'hFFFF_FFFF_FFFF_FFFF);

        // 3. x0 hardwired
        bus.rs1_addr       = 5'd0;
        bus.wb_RegWrite    = 1'b1;
        bus.wb_rd          = 5'd0;
        bus.wb_registerout = 64'hDEAD;
        #1;
        check("x0_before", bus.rs1_data, 64'd0);
        tick();
        bus.wb_RegWrite = 1'b0;
        #1;
        check("x0_after", bus.rs1_data, 64'd0);

        // 4. same-cycle read-after-write
        bus.wb_RegWrite    = 1'b1;
        bus.wb_rd          = 5'd3;
        bus.wb_registerout = 64'h11;
        tick();
        bus.wb_registerout = 64'h22;
        bus.rs1_addr       = 5'd3;
        bus.rs2_addr       = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 64'h22;
`else
        exp_pre = 64'h11;
`endif
        check("raw_pre_rs1", bus.rs1_data, exp_pre);
        check("raw_pre_rs2", bus.rs2_data, exp_pre);
        tick();
        bus.wb_RegWrite = 1'b0;
        #1;
        check("raw_post_rs1", bus.rs1_data, 64'h22);
        check("raw_post_rs2", bus.rs2_data, 64'h22);
        // write to x7 while port 1 reads x3 and port 2 reads x7: ports are independent
        bus.wb_RegWrite    = 1'b1;
        bus.wb_rd          = 5'd7;
        bus.wb_registerout = 64'h77;
        bus.rs2_addr       = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 64'h77;
`else
        exp_pre = 64'h0123_4567_89AB_CDEF;
`endif
        check("indep_rs1", bus.rs1_data, 64'h22);
        check("indep_rs2", bus.rs2_data, exp_pre);
        bus.wb_RegWrite = 1'b0;

        // 5. reset mid-sweep restarts the count
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (10) tick();
        check("mid_sweep_busy", 64'(bus.init_busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_ready(n_edges);
        check("restart_edges", 64'(n_edges), 64'd31);

        // 6. reset in READY clears stored data
        bus.wb_RegWrite    = 1'b1;
        bus.wb_rd          = 5'd9;
        bus.wb_registerout = 64'h55;
        tick();
        bus.wb_RegWrite = 1'b0;
        bus.rs1_addr    = 5'd9;
        #1;
        check("x9_written", bus.rs1_data, 64'h55);
        reset = 1'b1;
        #1;
        check("x9_during_reset", bus.rs1_data, 64'd0);
        tick();
        reset = 1'b0;
        #1;
        check("ready_reset_busy", 64'(bus.init_busy), 64'd1);
        repeat (15) tick();
        check("x9_mid_sweep", bus.rs1_data, 64'd0);
        wait_ready(n_edges);
        check("ready_reset_edges", 64'(n_edges + 15), 64'd31);
        check("x9_after_sweep", bus.rs1_data, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
